// File: rtl/ball_pkg.sv
// ball_pkg: shared constants and types for the ball motion block.
//   DIR_LEFT/DIR_RIGHT : encoding of the horizontal direction bit (i_XDir)
//   DIR_UP/DIR_DOWN    : encoding of the vertical direction bit (o_YDir)
//   ydir_state_e       : vertical bounce FSM state, encoded to match o_YDir
//   H_ACTIVE_DEF/V_ACTIVE_DEF : default visible raster size
package ball_pkg;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    typedef enum logic {
        YDIR_UP   = 1'b0,
        YDIR_DOWN = 1'b1
    } ydir_state_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
endpackage

// File: rtl/ball_motion_if.sv
// ball_motion_if: raster/direction inputs and ball outputs of ball_motion.
//   i_Col, i_Row   : raster counters from the sync generator
//   i_FrameStart   : one-cycle pulse per frame (vertical blank)
//   i_XDir         : horizontal direction from the hit detector
//   o_Ball         : registered per-pixel ball flag
//   o_BallX/o_BallY: ball left/top edge
//   o_YDir         : vertical direction (1 = down)
// Modports: master = raster/hit-detector side, slave = ball_motion.
interface ball_motion_if #(
    parameter int COL_W = 10,
    parameter int ROW_W = 10
);
    logic [COL_W-1:0] i_Col;
    logic [ROW_W-1:0] i_Row;
    logic             i_FrameStart;
    logic             i_XDir;
    logic             o_Ball;
    logic [COL_W-1:0] o_BallX;
    logic [ROW_W-1:0] o_BallY;
    logic             o_YDir;

    modport master (
        output i_Col, i_Row, i_FrameStart, i_XDir,
        input  o_Ball, o_BallX, o_BallY, o_YDir
    );

    modport slave (
        input  i_Col, i_Row, i_FrameStart, i_XDir,
        output o_Ball, o_BallX, o_BallY, o_YDir
    );
endinterface

// File: rtl/ball_motion_frame_divider.sv
// frame_divider: turns frame pulses into a step strobe once every DIV frames.
//   i_Clk   : clock, i_Reset : synchronous active-high reset
//   i_Tick  : frame pulse
//   o_Step  : registered one-cycle strobe, high the cycle after the DIV-th tick
module frame_divider #(
    parameter int DIV = 1
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Tick,
    output logic o_Step
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_q, step_d;

    always_comb begin
        cnt_d  = cnt_q;
        step_d = 1'b0;
        if (i_Tick) begin
            if (cnt_q == CW'(DIV - 1)) begin
                cnt_d  = '0;
                step_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

    assign o_Step = step_q;
endmodule

// File: rtl/ball_motion.sv
// ball_motion: owns the ball position, steps it every FRAME_DIV frames,
// bounces vertically on its own, and produces the registered per-pixel ball flag.
//   i_Clk   : pixel clock, i_Reset : synchronous active-high reset
//   bus     : ball_motion_if.slave (raster counters, frame pulse, XDir in;
//             ball flag, position and YDir out)
// Build option: BALL_ROUND_EN masks the four corner pixels of the ball
// (only when BALL_SIZE >= 4); motion is unaffected.
//
// Vertical FSM:
//   state     | meaning
//   YDIR_DOWN | ball moving down, bounces up at the bottom edge
//   YDIR_UP   | ball moving up, bounces down at the top edge
module ball_motion
    import ball_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int COL_W     = 10,
    parameter int ROW_W     = 10,
    parameter int BALL_SIZE = 8,
    parameter int SPEED     = 2,
    parameter int FRAME_DIV = 1,
    parameter int X_INIT    = 316,
    parameter int Y_INIT    = 236
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    ball_motion_if.slave       bus
);
    // One extra bit of headroom so sums and compares cannot overflow.
    localparam logic [COL_W:0] X_MAX = (COL_W+1)'(H_ACTIVE - BALL_SIZE);
    localparam logic [COL_W:0] SPD_X = (COL_W+1)'(SPEED);
    localparam logic [COL_W:0] SZ_X  = (COL_W+1)'(BALL_SIZE);
    localparam logic [ROW_W:0] Y_MAX = (ROW_W+1)'(V_ACTIVE - BALL_SIZE);
    localparam logic [ROW_W:0] V_Y   = (ROW_W+1)'(V_ACTIVE);
    localparam logic [ROW_W:0] SPD_Y = (ROW_W+1)'(SPEED);
    localparam logic [ROW_W:0] SZ_Y  = (ROW_W+1)'(BALL_SIZE);

    logic [COL_W-1:0] x_q, x_d;
    logic [ROW_W-1:0] y_q, y_d;
    ydir_state_e      state_q, state_d;
    logic             ball_q, ball_d;
    logic             step;

    logic [COL_W:0]   x_ext, col_ext;
    logic [ROW_W:0]   y_ext, row_ext;
    logic             in_box;

    frame_divider #(.DIV(FRAME_DIV)) u_div (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Tick  (bus.i_FrameStart),
        .o_Step  (step)
    );

    assign x_ext   = {1'b0, x_q};
    assign y_ext   = {1'b0, y_q};
    assign col_ext = {1'b0, bus.i_Col};
    assign row_ext = {1'b0, bus.i_Row};

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        state_d = state_q;
        if (step) begin
            if (bus.i_XDir == DIR_RIGHT) begin
                if (x_ext + SPD_X > X_MAX) x_d = COL_W'(X_MAX);
                else                       x_d = COL_W'(x_ext + SPD_X);
            end else begin
                if (x_ext < SPD_X) x_d = '0;
                else               x_d = COL_W'(x_ext - SPD_X);
            end

            // Landing exactly on an edge flips direction on the same step.
            case (state_q)
                YDIR_DOWN: begin
                    if (y_ext + SZ_Y + SPD_Y >= V_Y) begin
                        y_d     = ROW_W'(Y_MAX);
                        state_d = YDIR_UP;
                    end else begin
                        y_d = ROW_W'(y_ext + SPD_Y);
                    end
                end
                default: begin
                    if (y_ext <= SPD_Y) begin
                        y_d     = '0;
                        state_d = YDIR_DOWN;
                    end else begin
                        y_d = ROW_W'(y_ext - SPD_Y);
                    end
                end
            endcase
        end
    end

    always_comb begin
        in_box = (col_ext >= x_ext) && (col_ext < x_ext + SZ_X) &&
                 (row_ext >= y_ext) && (row_ext < y_ext + SZ_Y);
`ifdef BALL_ROUND_EN
        ball_d = in_box;
        if (BALL_SIZE >= 4) begin
            if ((col_ext == x_ext || col_ext == x_ext + SZ_X - 1'b1) &&
                (row_ext == y_ext || row_ext == y_ext + SZ_Y - 1'b1))
                ball_d = 1'b0;
        end
`else
        ball_d = in_box;
`endif
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            x_q     <= COL_W'(X_INIT);
            y_q     <= ROW_W'(Y_INIT);
            state_q <= YDIR_DOWN;
            ball_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            state_q <= state_d;
            ball_q  <= ball_d;
        end
    end

    assign bus.o_Ball  = ball_q;
    assign bus.o_BallX = x_q;
    assign bus.o_BallY = y_q;
    assign bus.o_YDir  = state_q;
endmodule
